sha_mm_ctrl: RTL and testbench



---
 rtl/sha_mm_ctrl_pkg.sv | 28 ++
 rtl/sha_mm_ctrl_if.sv | 13 +
 rtl/sha_mm_ctrl_seq.sv | 76 +++++++
 rtl/sha_mm_ctrl.sv | 121 ++++++++++++
 tb/tb_sha_mm_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_mm_ctrl_pkg.sv
// Shared constants, address helpers and FSM state type for the sha_mm_ctrl bus front-end.
package sha_mm_ctrl_pkg;

  localparam int unsigned CTRL_ADDR   = 0;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_FIRST  = 1;
  localparam int unsigned CTRL_DONE   = 2;
  localparam int unsigned CTRL_BUSY   = 3;
  localparam int unsigned CTRL_ERR    = 4;
  localparam int unsigned CTRL_IRQ_EN = 5;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE
  } state_e;

  function automatic int unsigned block_base();
    return CTRL_ADDR + 1;
  endfunction

  function automatic int unsigned digest_base(input int unsigned block_words);
    return block_base() + block_words;
  endfunction

endpackage

// File: rtl/sha_mm_ctrl_if.sv
// Avalon-MM slave bus bundle between the interconnect and sha_mm_ctrl.
interface sha_mm_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output write, read, address, writedata, input readdata);
  modport slave  (input write, read, address, writedata, output readdata);
endinterface

// File: rtl/sha_mm_ctrl_seq.sv
// Launch/wait/capture sequencer with a saturating watchdog on the core's completion pulse.
module sha_mm_ctrl_seq
  import sha_mm_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_req,
  input  logic core_done,
  output logic core_start,
  output logic capture,
  output logic timeout,
  output logic busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             wd_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == LAUNCH)
        wait_cnt <= '0;
      else if (state == WAIT && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // wait_cnt counts completed WAIT cycles, so the limit trips on the last allowed one
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      assign wd_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      assign wd_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_req) state_nx = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_nx = CAPTURE;
        end else if (wd_hit) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      CAPTURE: begin
        capture  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/sha_mm_ctrl.sv
// Avalon-MM register front-end for an iterative hash core: block buffer, CTRL/STATUS, digest capture.
// Optional interrupt output enabled by defining SHA_MM_CTRL_IRQ_EN.
module sha_mm_ctrl
  import sha_mm_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS    = 16,
  parameter int unsigned DIGEST_WORDS   = 5,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sha_mm_ctrl_if.slave              bus,
  output logic                      core_start,
  output logic                      core_first,
  output logic [32*BLOCK_WORDS-1:0] core_block,
  input  logic                      core_done,
  input  logic [32*DIGEST_WORDS-1:0] core_digest,
  output logic                      irq
);

  localparam int unsigned BLK_BASE = block_base();
  localparam int unsigned DIG_BASE = digest_base(BLOCK_WORDS);

  logic [31:0] blk_q [BLOCK_WORDS];
  logic [31:0] dig_q [DIGEST_WORDS];
  logic        first_q, done_q, err_q, irq_en_q;

  logic                   ctrl_wr, start_req, busy, capture, timeout, busy_viol, blk_hit;
  logic [BLOCK_WORDS-1:0] blk_wr;
  logic [31:0]            rd_mux;

  assign ctrl_wr   = bus.write && (bus.address == ADDR_W'(CTRL_ADDR));
  assign start_req = ctrl_wr && bus.writedata[CTRL_START] && !busy;

  always_comb begin
    blk_wr = '0;
    for (int unsigned i = 0; i < BLOCK_WORDS; i++)
      blk_wr[i] = bus.write && (bus.address == ADDR_W'(BLK_BASE + i));
  end

  assign blk_hit   = |blk_wr;
  assign busy_viol = busy && (blk_hit || (ctrl_wr && bus.writedata[CTRL_START]));

  sha_mm_ctrl_seq #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_req  (start_req),
    .core_done  (core_done),
    .core_start (core_start),
    .capture    (capture),
    .timeout    (timeout),
    .busy       (busy)
  );

  assign core_first = core_start & first_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) blk_q[i] <= '0;
      for (int unsigned i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
      core_block   <= '0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bus.readdata <= '0;
    end else begin
      // snapshot uses the pre-edge buffer, so a same-cycle block write is not included
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
        if (blk_wr[i] && !busy) blk_q[i] <= bus.writedata;
        if (start_req) core_block[32*i +: 32] <= blk_q[i];
      end
      if (capture)
        for (int unsigned i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= core_digest[32*i +: 32];

      if (core_start) first_q <= 1'b0;
      if (ctrl_wr)    first_q <= bus.writedata[CTRL_FIRST];

      if (ctrl_wr && bus.writedata[CTRL_DONE]) done_q <= 1'b0;
      if (capture)                             done_q <= 1'b1;

      if (ctrl_wr && bus.writedata[CTRL_ERR]) err_q <= 1'b0;
      if (timeout || busy_viol)               err_q <= 1'b1;

      bus.readdata <= bus.read ? rd_mux : '0;
    end
  end

`ifdef SHA_MM_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
      irq <= irq_en_q & (done_q | err_q);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (bus.address == ADDR_W'(CTRL_ADDR)) begin
      rd_mux[CTRL_FIRST]  = first_q;
      rd_mux[CTRL_DONE]   = done_q;
      rd_mux[CTRL_BUSY]   = busy;
      rd_mux[CTRL_ERR]    = err_q;
      rd_mux[CTRL_IRQ_EN] = irq_en_q;
    end
    for (int unsigned i = 0; i < BLOCK_WORDS; i++)
      if (bus.address == ADDR_W'(BLK_BASE + i)) rd_mux = blk_q[i];
    for (int unsigned i = 0; i < DIGEST_WORDS; i++)
      if (bus.address == ADDR_W'(DIG_BASE + i)) rd_mux = dig_q[i];
  end

endmodule

// File: tb/tb_sha_mm_ctrl.sv
// Directed bench for sha_mm_ctrl with a fixed-latency hash core stub.
module tb_sha_mm_ctrl;

  localparam int BW = 16;
  localparam int DW = 5;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha_mm_ctrl_if #(.ADDR_W(AW)) bus ();

  logic            core_start, core_first, irq;
  logic            core_done = 1'b0;
  logic [32*BW-1:0] core_block;
  logic [32*DW-1:0] core_digest;
  logic [32*DW-1:0] stub_digest = '0;

  int checks = 0;
  int errors = 0;

  sha_mm_ctrl #(
    .BLOCK_WORDS    (BW),
    .DIGEST_WORDS   (DW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .core_start  (core_start),
    .core_first  (core_first),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_digest (core_digest),
    .irq         (irq)
  );

  // core stub: pulses done stub_lat edges after sampling core_start
  logic stub_en = 1'b1;
  int   stub_lat = 4;
  int   pend = 0;
  assign core_digest = stub_digest;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start && stub_en) pend <= stub_lat;
    else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) core_done <= 1'b1;
    end
  end

  int               start_cnt = 0;
  logic             last_first = 1'b0;
  logic [32*BW-1:0] last_block = '0;

  always @(posedge clk) begin
    if (core_start) begin
      start_cnt  <= start_cnt + 1;
      last_first <= core_first;
      last_block <= core_block;
    end
  end

  localparam logic [32*DW-1:0] DIG_ABC =
    {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
  localparam logic [32*DW-1:0] DIG_TWO =
    {32'h55667788, 32'h01234567, 32'hcafef00d, 32'hfeedface, 32'h0badc0de};

  // all bus tasks are entered and left on a falling edge
  task automatic bus_write(input int a, input logic [31:0] d);
    bus.write = 1'b1; bus.address = AW'(a); bus.writedata = d;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    bus.read = 1'b1; bus.address = AW'(a);
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic poll_done(output int k);
    k = -1;
    bus.read = 1'b1; bus.address = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!bus.readdata[3] && (bus.readdata[2] || bus.readdata[4])) begin
        k = i;
        break;
      end
    end
    bus.read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_read(0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", d, 32'h0); end
    bus_read(1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_blk1 got %h exp %h", d, 32'h0); end
    bus_read(17, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_dig0 got %h exp %h", d, 32'h0); end
    checks++;
    if ({core_start, core_first, irq} !== 3'b000) begin
      errors++; $display("FAIL reset_outs got %b exp %b", {core_start, core_first, irq}, 3'b000);
    end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL reset_block got %h exp 0", core_block); end
  endtask

  task automatic test_sha1_abc();
    logic [31:0] d;
    int k, s0;
    stub_lat = 4; stub_digest = DIG_ABC;
    for (int i = 1; i <= BW; i++)
      bus_write(i, (i == 1) ? 32'h61626380 : (i == 16) ? 32'h00000018 : 32'h0);
    s0 = start_cnt;
    bus_write(0, 32'h3);
    poll_done(k);
    checks++; if (k !== 8) begin errors++; $display("FAIL abc_latency got %0d exp %0d", k, 8); end
    bus_read(0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL abc_status got %h exp %h", d, 32'h4); end
    for (int i = 0; i < DW; i++) begin
      bus_read(17 + i, d);
      checks++;
      if (d !== DIG_ABC[32*i +: 32]) begin
        errors++; $display("FAIL abc_digest%0d got %h exp %h", i, d, DIG_ABC[32*i +: 32]);
      end
    end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL abc_starts got %0d exp 1", start_cnt - s0); end
    checks++; if (last_first !== 1'b1) begin errors++; $display("FAIL abc_first got %b exp 1", last_first); end
    checks++;
    if (last_block[31:0] !== 32'h61626380 || last_block[511:480] !== 32'h18) begin
      errors++; $display("FAIL abc_block got %h/%h exp 61626380/00000018", last_block[31:0], last_block[511:480]);
    end
  endtask

  task automatic test_two_block();
    logic [31:0] d;
    int k, s0;
    bus_write(0, 32'h4);
    bus_read(0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL chain_clear got %h exp %h", d, 32'h0); end
    bus_write(1, 32'h11111111);
    bus_write(2, 32'h22222222);
    stub_digest = DIG_TWO;
    s0 = start_cnt;
    bus_write(0, 32'h1);
    poll_done(k);
    checks++; if (k !== 8) begin errors++; $display("FAIL chain_latency got %0d exp %0d", k, 8); end
    bus_read(0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL chain_status got %h exp %h", d, 32'h4); end
    for (int i = 0; i < DW; i++) begin
      bus_read(17 + i, d);
      checks++;
      if (d !== DIG_TWO[32*i +: 32]) begin
        errors++; $display("FAIL chain_digest%0d got %h exp %h", i, d, DIG_TWO[32*i +: 32]);
      end
    end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL chain_starts got %0d exp 1", start_cnt - s0); end
    checks++; if (last_first !== 1'b0) begin errors++; $display("FAIL chain_first got %b exp 0", last_first); end
    checks++;
    if (last_block[63:32] !== 32'h22222222) begin
      errors++; $display("FAIL chain_block got %h exp %h", last_block[63:32], 32'h22222222);
    end
    bus_write(17, 32'h12345678);
    bus_read(17, d);
    checks++; if (d !== DIG_TWO[31:0]) begin errors++; $display("FAIL digest_ro got %h exp %h", d, DIG_TWO[31:0]); end
    @(negedge clk);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL rd_idle got %h exp %h", bus.readdata, 32'h0); end
    bus_write(40, 32'hffffffff);
    bus_read(40, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_busy_protect();
    logic [31:0] d;
    int k, s0;
    stub_lat = 6;
    bus_write(0, 32'h4);
    bus_write(5, 32'h55555555);
    s0 = start_cnt;
    bus_write(0, 32'h1);
    @(negedge clk);
    bus_write(5, 32'hdeadbeef);
    checks++;
    if (core_block[32*4 +: 32] !== 32'h55555555) begin
      errors++; $display("FAIL busy_snapshot got %h exp %h", core_block[32*4 +: 32], 32'h55555555);
    end
    bus_write(0, 32'h1);
    poll_done(k);
    checks++; if (k < 1) begin errors++; $display("FAIL busy_poll got %0d exp done", k); end
    bus_read(0, d);
    checks++; if (d !== 32'h14) begin errors++; $display("FAIL busy_status got %h exp %h", d, 32'h14); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL busy_starts got %0d exp 1", start_cnt - s0); end
    bus_read(5, d);
    checks++; if (d !== 32'h55555555) begin errors++; $display("FAIL busy_word5 got %h exp %h", d, 32'h55555555); end
    bus_write(0, 32'h10);
    bus_read(0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL err_clear got %h exp %h", d, 32'h4); end
  endtask

  task automatic test_status_race();
    logic [31:0] d;
    stub_lat = 4;
    bus_write(0, 32'h5);
    bus_read(0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL clear_and_start got %h exp %h", d, 32'h8); end
    repeat (5) @(negedge clk);
    bus_write(0, 32'h4);
    bus_read(0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL set_wins got %h exp %h", d, 32'h4); end
  endtask

  task automatic test_watchdog();
    logic [31:0] d;
    int k, s0;
    bus_write(0, 32'h4);
    stub_en = 1'b0;
    s0 = start_cnt;
    bus_write(0, 32'h1);
    poll_done(k);
    checks++; if (k !== 10) begin errors++; $display("FAIL wd_cycles got %0d exp %0d", k, 10); end
    bus_read(0, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL wd_status got %h exp %h", d, 32'h10); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL wd_starts got %0d exp 1", start_cnt - s0); end
    bus_read(19, d);
    checks++; if (d !== DIG_TWO[95:64]) begin errors++; $display("FAIL wd_digest got %h exp %h", d, DIG_TWO[95:64]); end
    bus_write(0, 32'h10);
    stub_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d;
    int s0;
    stub_lat = 6;
    bus_write(0, 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL rst_nostart got %0d exp %0d", start_cnt, s0); end
    bus_read(0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", d, 32'h0); end
    bus_read(17, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_digest got %h exp %h", d, 32'h0); end
    bus_read(2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_block got %h exp %h", d, 32'h0); end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL rst_snapshot got %h exp 0", core_block); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    stub_lat = 4;
    bus_write(0, 32'h23);
`ifdef SHA_MM_CTRL_IRQ_EN
    repeat (6) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_done_edge got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    bus_write(0, 32'h24);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
    bus_read(0, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL irq_status got %h exp %h", d, 32'h20); end
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b exp 0", irq); end
    end
    bus_read(0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL irq_bit5 got %h exp %h", d, 32'h4); end
`endif
  endtask

  initial begin
    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_sha1_abc();
    test_two_block();
    test_busy_protect();
    test_status_race();
    test_watchdog();
    test_reset_mid_wait();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got running exp finished");
    $fatal(1, "time limit");
  end

endmodule
